// File: rtl/neighborhood_stats.sv
// neighborhood_stats: weighted mean and integer standard deviation of a serial weighted pixel window,
// presented with the window's centre pixel on a valid/ready output.
module neighborhood_stats #(
  parameter int PIX_W = 16,
  parameter int WGT_W = 4,
  parameter int N     = 8,
  parameter int ACC_W = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [31:0]      s_pixel,
  input  logic [WGT_W-1:0] s_weight,
  input  logic [31:0]      s_center,
  input  logic             s_last,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [31:0]      weighted_mean,
  output logic [31:0]      std_dev,
  output logic [31:0]      pixel_center,
  output logic             zero_weight
);
  localparam int SW = $clog2(ACC_W + 1);
  typedef enum logic [2:0] {ACC, DIV_MEAN, DIV_SQ, VAR, SQRT, OUT} state_t;
  state_t r_state, w_next;
  logic [ACC_W-1:0] r_w, r_s1, r_s2, r_dq, r_dr, r_mean, r_q2;
  logic [4:0] r_cnt;
  logic [SW-1:0] r_step;
  logic [31:0] r_center, r_rad;
  logic r_zw;
  logic [21:0] r_sr;
  logic [15:0] r_sq;
  logic w_hs, w_close, w_div_end, w_sqrt_end, w_ge, w_unused;
  logic [ACC_W-1:0] w_px, w_wx, w_w_n, w_s1_n, w_s2_n, w_dq_n, w_msq;
  logic [ACC_W:0] w_dt;
  logic [23:0] w_rt;
  logic [21:0] w_rn;
  logic [15:0] w_sq_n;
  assign s_ready    = r_state == ACC;
  assign m_valid    = r_state == OUT;
  assign w_hs       = s_valid & s_ready;
  assign w_close    = s_last | (r_cnt == 5'(N - 1));
  assign w_px       = ACC_W'(s_pixel[PIX_W-1:0]);
  assign w_wx       = ACC_W'(s_weight) * w_px;
  assign w_w_n      = r_w + ACC_W'(s_weight);
  assign w_s1_n     = r_s1 + w_wx;
  assign w_s2_n     = r_s2 + w_wx * w_px;
  assign w_unused   = ^s_pixel[31:PIX_W];
  // restoring divide step: dividend shifts out of r_dq, quotient shifts in
  assign w_dt       = {r_dr, r_dq[ACC_W-1]};
  assign w_ge       = w_dt >= {1'b0, r_w};
  assign w_dq_n     = {r_dq[ACC_W-2:0], w_ge};
  assign w_msq      = r_mean * r_mean;
  // non-restoring sqrt step: two radicand bits per cycle, signed partial remainder
  assign w_rt       = {r_sr, r_rad[31:30]};
  assign w_rn       = 22'(r_sr[21] ? w_rt + 24'({r_sq, 2'b11}) : w_rt - 24'({r_sq, 2'b01}));
  assign w_sq_n     = {r_sq[14:0], ~w_rn[21]};
  assign w_div_end  = r_step == SW'(ACC_W - 1);
  assign w_sqrt_end = r_step == SW'(15);
  always_ff @(posedge clk)
    r_state <= reset ? ACC : w_next;
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ACC:      w_next = (w_hs && w_close) ? DIV_MEAN : ACC;
      DIV_MEAN: w_next = w_div_end ? DIV_SQ : DIV_MEAN;
      DIV_SQ:   w_next = w_div_end ? VAR : DIV_SQ;
      VAR:      w_next = SQRT;
      SQRT:     w_next = w_sqrt_end ? OUT : SQRT;
      OUT:      w_next = m_ready ? ACC : OUT;
      default:  w_next = ACC;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_w           <= '0;
      r_s1          <= '0;
      r_s2          <= '0;
      r_cnt         <= '0;
      r_step        <= '0;
      r_dq          <= '0;
      r_dr          <= '0;
      r_mean        <= '0;
      r_q2          <= '0;
      r_center      <= '0;
      r_zw          <= 1'b0;
      r_rad         <= '0;
      r_sr          <= '0;
      r_sq          <= '0;
      weighted_mean <= '0;
      std_dev       <= '0;
      pixel_center  <= '0;
      zero_weight   <= 1'b0;
    end else begin
      r_step <= (w_next != r_state) ? '0 : r_step + SW'(1);
      if (r_state == ACC && w_hs) begin
        r_w   <= w_w_n;
        r_s1  <= w_s1_n;
        r_s2  <= w_s2_n;
        r_cnt <= r_cnt + 5'd1;
        r_dq  <= w_s1_n;
        r_dr  <= '0;
        if (w_close) begin
          r_center <= s_center;
          r_zw     <= w_w_n == '0;
        end
      end
      if (r_state == DIV_MEAN || r_state == DIV_SQ) begin
        r_dq <= w_dq_n;
        r_dr <= ACC_W'(w_ge ? w_dt - {1'b0, r_w} : w_dt);
        if (w_div_end && r_state == DIV_MEAN) begin
          r_mean <= r_zw ? '0 : w_dq_n;
          r_dq   <= r_s2;
          r_dr   <= '0;
        end
        if (w_div_end && r_state == DIV_SQ)
          r_q2 <= r_zw ? '0 : w_dq_n;
      end
      if (r_state == VAR) begin
        r_rad <= (r_q2 > w_msq) ? 32'(r_q2 - w_msq) : '0;
        r_sr  <= '0;
        r_sq  <= '0;
      end
      if (r_state == SQRT) begin
        r_rad <= {r_rad[29:0], 2'b00};
        r_sr  <= w_rn;
        r_sq  <= w_sq_n;
        if (w_sqrt_end) begin
          weighted_mean <= r_mean[31:0];
          std_dev       <= {16'd0, w_sq_n};
          pixel_center  <= r_center;
          zero_weight   <= r_zw;
        end
      end
      if (r_state == OUT && m_ready) begin
        r_w   <= '0;
        r_s1  <= '0;
        r_s2  <= '0;
        r_cnt <= '0;
      end
    end
  end
endmodule

// File: tb/tb_neighborhood_stats.sv
// tb_neighborhood_stats: directed and random windows checked against an arithmetic model of
// weighted mean / std-dev, latency, backpressure and reset abort.
module tb_neighborhood_stats;
  logic        clk, reset, s_valid, s_ready, s_last, m_valid, m_ready, zero_weight;
  logic [31:0] s_pixel, s_center, weighted_mean, std_dev, pixel_center;
  logic [3:0]  s_weight;
  int checks = 0, failures = 0;
  int unsigned px[8];
  int unsigned wg[8];

  neighborhood_stats dut (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready), .s_pixel(s_pixel),
    .s_weight(s_weight), .s_center(s_center), .s_last(s_last), .m_valid(m_valid),
    .m_ready(m_ready), .weighted_mean(weighted_mean), .std_dev(std_dev),
    .pixel_center(pixel_center), .zero_weight(zero_weight)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic garbage(input bit v);
    s_valid  = v;
    s_pixel  = $urandom;
    s_weight = 4'($urandom);
    s_last   = 1'($urandom);
    s_center = $urandom;
  endtask

  task automatic run_window(input int n, input bit use_last, input logic [31:0] ctr,
                            input int hold, input int abort);
    longint unsigned w, s1, s2, x, mean, q2, v, sd, t;
    int lat, srdy;
    logic [63:0] snap_a, snap_b;
    w = 0; s1 = 0; s2 = 0;
    for (int i = 0; i < n; i++) begin
      x = longint'(px[i] & 32'hFFFF);
      w += wg[i];
      s1 += wg[i] * x;
      s2 += wg[i] * x * x;
    end
    mean = (w == 0) ? 0 : s1 / w;
    q2 = (w == 0) ? 0 : s2 / w;
    v = (q2 > mean * mean) ? q2 - mean * mean : 0;
    sd = 0;
    for (int b = 15; b >= 0; b--) begin
      t = sd | (64'd1 << b);
      if (t * t <= v) sd = t;
    end
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        garbage(1'b0);
      end
      @(negedge clk);
      chk("beat_ready", s_ready, 1);
      s_valid = 1; s_pixel = px[i]; s_weight = 4'(wg[i]); s_center = ctr;
      s_last = use_last && (i == n - 1);
      @(posedge clk);
    end
    lat = 0; srdy = 0;
    while (lat < 400) begin
      #1;
      if (m_valid) break;
      if (abort > 0 && lat == abort) begin
        garbage(1'b0);
        reset = 1;
        @(posedge clk);
        #1 reset = 0;
        chk("rst_m_valid", m_valid, 0);
        chk("rst_s_ready", s_ready, 1);
        chk("rst_mean", weighted_mean, 0);
        chk("rst_std", std_dev, 0);
        chk("rst_center", pixel_center, 0);
        chk("rst_zw", zero_weight, 0);
        return;
      end
      if (s_ready) srdy++;
      garbage(1'($urandom));
      @(posedge clk);
      lat++;
    end
    garbage(1'b0);
    chk("latency", lat, 145);
    chk("busy_s_ready", srdy, 0);
    chk("out_s_ready", s_ready, 0);
    chk("mean", weighted_mean, mean);
    chk("std_dev", std_dev, sd);
    chk("center", pixel_center, ctr);
    chk("zero_weight", zero_weight, w == 0);
    snap_a = {weighted_mean, std_dev};
    snap_b = {29'd0, m_valid, s_ready, zero_weight, pixel_center};
    for (int c = 0; c < hold; c++) begin
      m_ready = 0;
      @(posedge clk);
      #1;
      chk("hold_data", {weighted_mean, std_dev}, snap_a);
      chk("hold_ctl", {29'd0, m_valid, s_ready, zero_weight, pixel_center}, snap_b);
    end
    m_ready = 1;
    @(posedge clk);
    #1 m_ready = 0;
    chk("post_m_valid", m_valid, 0);
    chk("post_s_ready", s_ready, 1);
  endtask

  initial begin
    reset = 1; m_ready = 0;
    garbage(1'b0);
    repeat (2) @(posedge clk);
    #1 reset = 0;
    chk("init_m_valid", m_valid, 0);
    chk("init_s_ready", s_ready, 1);
    chk("init_mean", weighted_mean, 0);
    chk("init_std", std_dev, 0);
    chk("init_center", pixel_center, 0);
    chk("init_zw", zero_weight, 0);
    // nominal
    px = '{10, 12, 14, 16, 10, 12, 14, 16};
    wg = '{1, 1, 1, 1, 1, 1, 1, 1};
    run_window(8, 1, 99, 0, 0);
    chk("t1_mean", weighted_mean, 13);
    chk("t1_std", std_dev, 2);
    // weighted short window
    px[0] = 100; px[1] = 200; wg[0] = 3; wg[1] = 1;
    run_window(2, 1, 7, 1, 0);
    chk("t2_mean", weighted_mean, 125);
    chk("t2_std", std_dev, 43);
    // zero weight
    for (int i = 0; i < 8; i++) begin px[i] = $urandom; wg[i] = 0; end
    run_window(8, 1, 55, 0, 0);
    chk("t3_zw", zero_weight, 1);
    // full scale, closes on the N-th beat, upper pixel bits ignored
    for (int i = 0; i < 8; i++) begin px[i] = 32'hFFFF_FFFF; wg[i] = 15; end
    run_window(8, 0, 32'hABCD_0123, 0, 0);
    chk("t4_mean", weighted_mean, 65535);
    chk("t4_std", std_dev, 0);
    // backpressure
    px = '{10, 12, 14, 16, 10, 12, 14, 16};
    wg = '{1, 1, 1, 1, 1, 1, 1, 1};
    run_window(8, 1, 99, 20, 0);
    // reset during SQRT, then a clean window
    px[0] = 100; px[1] = 200; wg[0] = 3; wg[1] = 1;
    run_window(2, 1, 7, 0, 138);
    px = '{10, 12, 14, 16, 10, 12, 14, 16};
    wg = '{1, 1, 1, 1, 1, 1, 1, 1};
    run_window(8, 1, 99, 0, 0);
    chk("t6_mean", weighted_mean, 13);
    chk("t6_std", std_dev, 2);
    // random windows
    for (int k = 0; k < 12; k++) begin
      int n;
      n = $urandom_range(1, 8);
      for (int i = 0; i < 8; i++) begin
        px[i] = $urandom;
        wg[i] = $urandom_range(0, 15);
      end
      run_window(n, (n < 8) ? 1'b1 : 1'($urandom), $urandom, $urandom_range(0, 3), 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
